alu_share_arbiter: RTL

Shares the single 32-bit ALU (select inputs S0..S2, carry-in Ci, outputs F and Co) between two requesters: port 0 is the main execute datapath and port 1 is the address/branch unit. It accepts operations through valid/ready handshakes and arbitrates round-robin. It registers operands into an execute stage that drives the ALU, then captures F/Co into a per-requester response register that is held until consumed. It also derives Ci from the opcode and flags unsupported opcodes.

---
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin front end for a shared combinational ALU:
// request handshake -> execute register driving the ALU -> per-requester held result.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_co,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_co,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  output logic             alu_ci,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_co
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_XOR  = 3'b001,
    OP_SUB  = 3'b010,
    OP_BAD3 = 3'b011,
    OP_SLT  = 3'b100,
    OP_NOR  = 3'b101,
    OP_BAD6 = 3'b110,
    OP_OR   = 3'b111
  } op_e;

  logic             r_x_valid;
  logic             r_x_owner;
  logic             r_last_grant;
  logic [2:0]       r_x_op;
  logic [WIDTH-1:0] r_x_a;
  logic [WIDTH-1:0] r_x_b;
  logic [1:0]       r_rsp_valid;
  logic [1:0]       r_rsp_co;
  logic [1:0]       r_rsp_err;
  logic [WIDTH-1:0] r_rsp_data [2];

  logic [1:0] w_req_valid;
  logic [1:0] w_rsp_ready;
  logic       w_advance;
  logic       w_can_accept;
  logic       w_accept;
  logic       w_grant;
  logic       w_illegal;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};

  always_comb begin
    w_advance    = r_x_valid && (!r_rsp_valid[r_x_owner] || w_rsp_ready[r_x_owner]);
    w_can_accept = !r_x_valid || w_advance;
    // A contest goes to whichever requester did not win the previous grant.
    w_grant      = (&w_req_valid) ? ~r_last_grant : req1_valid;
    w_accept     = w_can_accept && (|w_req_valid);
    w_illegal    = (r_x_op == OP_BAD3) || (r_x_op == OP_BAD6);
  end

  assign req0_ready = w_accept && !w_grant;
  assign req1_ready = w_accept && w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_valid    <= 1'b0;
      r_x_owner    <= 1'b0;
      r_last_grant <= 1'b1;
      r_x_op       <= OP_ADD;
      r_x_a        <= '0;
      r_x_b        <= '0;
    end else if (w_accept) begin
      r_x_valid    <= 1'b1;
      r_x_owner    <= w_grant;
      r_last_grant <= w_grant;
      r_x_op       <= w_grant ? req1_op : req0_op;
      r_x_a        <= w_grant ? req1_a : req0_a;
      r_x_b        <= w_grant ? req1_b : req0_b;
    end else if (w_advance) begin
      r_x_valid    <= 1'b0;
    end
  end

  // A fresh result landing in a slot takes priority over that slot's consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid   <= '0;
      r_rsp_co      <= '0;
      r_rsp_err     <= '0;
      r_rsp_data[0] <= '0;
      r_rsp_data[1] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (w_advance && (r_x_owner == 1'(i))) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_data[i]  <= w_illegal ? '0 : alu_f;
          r_rsp_co[i]    <= !w_illegal && alu_co;
          r_rsp_err[i]   <= w_illegal;
        end else if (w_rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign alu_a   = r_x_a;
  assign alu_b   = r_x_b;
  assign alu_sel = r_x_op;
  assign alu_ci  = (r_x_op == OP_SUB);

  assign rsp0_valid = r_rsp_valid[0];
  assign rsp0_data  = r_rsp_data[0];
  assign rsp0_co    = r_rsp_co[0];
  assign rsp0_err   = r_rsp_err[0];
  assign rsp1_valid = r_rsp_valid[1];
  assign rsp1_data  = r_rsp_data[1];
  assign rsp1_co    = r_rsp_co[1];
  assign rsp1_err   = r_rsp_err[1];

endmodule
